// File: rtl/ex_mem_stage.sv
// ex_mem_stage
// Execute stage of the 5-stage MIPS-style core, together with the EX/MEM
// pipeline register it feeds.
//   - Takes the ID_EX register contents and decodes the ALU control.
//   - Forwards operands from EX/MEM and MEM/WB.
//   - Runs the ALU and resolves branches.
//   - Captures the results into the EX/MEM register. That register owns
//     stall, flush and the one-slot squash after a taken branch.

module ex_mem_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst_n,

    // ID_EX pipeline register contents
    input  logic [REGW-1:0] rs1_ID_EX,
    input  logic [REGW-1:0] rs2_ID_EX,
    input  logic [REGW-1:0] rd_ID_EX,
    input  logic [5:0]      funct_ID_EX,
    input  logic [XLEN-1:0] word_ID_EX,
    input  logic [XLEN-1:0] read_data1_ID_EX,
    input  logic [XLEN-1:0] read_data2_ID_EX,
    input  logic [XLEN-1:0] PC_ID_EX,
    input  logic [1:0]      ALUOp_ID_EX,
    input  logic            ALUSrc_ID_EX,
    input  logic            Mem_Read_ID_EX,
    input  logic            Mem_Write_ID_EX,
    input  logic            PcSrc_ID_EX,
    input  logic            Mem_to_Reg_ID_EX,
    input  logic            Reg_Write_ID_EX,
    input  logic            RegDst_ID_EX,

    // MEM/WB write-back path, used as the second forwarding source
    input  logic [REGW-1:0] wb_rd,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_data,

    // Pipeline control
    input  logic            stall,
    input  logic            flush_ex,

    // EX/MEM pipeline register
    output logic [XLEN-1:0] alu_result_EX_MEM,
    output logic [XLEN-1:0] write_data_EX_MEM,
    output logic [REGW-1:0] dest_EX_MEM,
    output logic            zero_EX_MEM,
    output logic            Mem_Read_EX_MEM,
    output logic            Mem_Write_EX_MEM,
    output logic            Mem_to_Reg_EX_MEM,
    output logic            Reg_Write_EX_MEM,
    output logic            branch_taken_EX_MEM,
    output logic [XLEN-1:0] branch_target_EX_MEM
);

    // Internal ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    // ALUOp classes coming from the main decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    // R-type funct encodings
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    // ------------------------------------------------------------------
    // Operand forwarding. Operand A (index 0) and operand B (index 1)
    // use identical rules, so both are built from one generate loop.
    // ------------------------------------------------------------------
    logic [REGW-1:0] src_idx [2];
    logic [XLEN-1:0] rf_val  [2];
    logic [XLEN-1:0] fwd_val [2];

    assign src_idx[0] = rs1_ID_EX;
    assign src_idx[1] = rs2_ID_EX;
    assign rf_val[0]  = read_data1_ID_EX;
    assign rf_val[1]  = read_data2_ID_EX;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic ex_hit;
            logic wb_hit;

            // A load in EX/MEM has no data yet. Its ALU result is only
            // the address, so it is never forwarded from this level.
            assign ex_hit = Reg_Write_EX_MEM && !Mem_to_Reg_EX_MEM &&
                            (dest_EX_MEM != '0) &&
                            (dest_EX_MEM == src_idx[gi]);
            assign wb_hit = wb_reg_write && (wb_rd != '0) &&
                            (wb_rd == src_idx[gi]);

            // The younger result (EX/MEM) takes precedence over MEM/WB.
            assign fwd_val[gi] = ex_hit ? alu_result_EX_MEM :
                                 (wb_hit ? wb_data : rf_val[gi]);
        end
    endgenerate

    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] alu_b;

    assign fwd_a = fwd_val[0];
    assign fwd_b = fwd_val[1];
    assign alu_b = ALUSrc_ID_EX ? word_ID_EX : fwd_b;

    // ------------------------------------------------------------------
    // ALU control and ALU
    // ------------------------------------------------------------------
    logic [2:0]      alu_op;
    logic [XLEN-1:0] alu_result_next;
    logic            zero_next;

    // Decode ALUOp and the funct field into an internal ALU operation.
    // An unrecognised funct falls back to add.
    always_comb begin
        alu_op = ALU_ADD;
        case (ALUOp_ID_EX)
            ALUOP_ADD: alu_op = ALU_ADD;
            ALUOP_SUB: alu_op = ALU_SUB;
            ALUOP_OR:  alu_op = ALU_OR;
            ALUOP_RTYPE: begin
                case (funct_ID_EX)
                    FUNCT_ADD: alu_op = ALU_ADD;
                    FUNCT_SUB: alu_op = ALU_SUB;
                    FUNCT_AND: alu_op = ALU_AND;
                    FUNCT_OR:  alu_op = ALU_OR;
                    FUNCT_SLT: alu_op = ALU_SLT;
                    default:   alu_op = ALU_ADD;
                endcase
            end
            default: alu_op = ALU_ADD;
        endcase
    end

    // Compute the ALU result. Arithmetic wraps and never traps.
    // slt compares as signed and returns 1 or 0.
    always_comb begin
        alu_result_next = '0;
        case (alu_op)
            ALU_ADD: alu_result_next = fwd_a + alu_b;
            ALU_SUB: alu_result_next = fwd_a - alu_b;
            ALU_AND: alu_result_next = fwd_a & alu_b;
            ALU_OR:  alu_result_next = fwd_a | alu_b;
            ALU_SLT: alu_result_next = {{(XLEN-1){1'b0}},
                                        ($signed(fwd_a) < $signed(alu_b))};
            default: alu_result_next = fwd_a + alu_b;
        endcase
    end

    assign zero_next = (alu_result_next == '0);

    // ------------------------------------------------------------------
    // Destination select and branch resolution
    // ------------------------------------------------------------------
    logic [REGW-1:0] dest_next;
    logic            taken_next;
    logic [XLEN-1:0] branch_target_next;

    assign dest_next          = RegDst_ID_EX ? rd_ID_EX : rs2_ID_EX;
    assign taken_next         = PcSrc_ID_EX && (fwd_a == fwd_b);
    assign branch_target_next = PC_ID_EX + XLEN'(4) + (word_ID_EX << 2);

    // ------------------------------------------------------------------
    // EX/MEM register control
    // ------------------------------------------------------------------
    logic load_en;
    logic bubble;

    // A flush overrides a stall. A bubble is needed in two cases: on a
    // flush, and when the register already holds a taken branch. In the
    // second case the instruction now in EX is on the wrong path.
    assign load_en = flush_ex || !stall;
    assign bubble  = flush_ex || branch_taken_EX_MEM;

    // Capture data fields on every enabled cycle. In a bubble these fields
    // are don't-care because every control bit is cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_result_EX_MEM    <= '0;
            write_data_EX_MEM    <= '0;
            dest_EX_MEM          <= '0;
            zero_EX_MEM          <= 1'b0;
            branch_target_EX_MEM <= '0;
        end else if (load_en) begin
            alu_result_EX_MEM    <= alu_result_next;
            write_data_EX_MEM    <= fwd_b;
            dest_EX_MEM          <= dest_next;
            zero_EX_MEM          <= zero_next;
            branch_target_EX_MEM <= branch_target_next;
        end
    end

    // Capture control bits. A bubble clears them, which also clears
    // branch_taken, so the squash covers exactly one instruction and a
    // branch in the squashed slot is never taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Mem_Read_EX_MEM     <= 1'b0;
            Mem_Write_EX_MEM    <= 1'b0;
            Mem_to_Reg_EX_MEM   <= 1'b0;
            Reg_Write_EX_MEM    <= 1'b0;
            branch_taken_EX_MEM <= 1'b0;
        end else if (load_en) begin
            if (bubble) begin
                Mem_Read_EX_MEM     <= 1'b0;
                Mem_Write_EX_MEM    <= 1'b0;
                Mem_to_Reg_EX_MEM   <= 1'b0;
                Reg_Write_EX_MEM    <= 1'b0;
                branch_taken_EX_MEM <= 1'b0;
            end else begin
                Mem_Read_EX_MEM     <= Mem_Read_ID_EX;
                Mem_Write_EX_MEM    <= Mem_Write_ID_EX;
                Mem_to_Reg_EX_MEM   <= Mem_to_Reg_ID_EX;
                Reg_Write_EX_MEM    <= Reg_Write_ID_EX;
                branch_taken_EX_MEM <= taken_next;
            end
        end
    end

endmodule
